pulse_stretcher: RTL and testbench

Converts single-cycle request pulses, such as the one-shot output of the button synchronizer, into visible fixed-width level pulses for LEDs or slow downstream logic. Each accepted input pulse produces one output blink of HOLD_CYCLES high followed by GAP_CYCLES low. Pulses that arrive during a blink are optionally queued so that every press yields a distinct blink. The block sits between the button/UART event sources and the board indicators.

---
 rtl/pulse_pkg.sv | 14 +
 rtl/pend_counter.sv | 40 ++++
 rtl/pulse_stretcher.sv | 128 ++++++++++++
 tb/tb_pulse_stretcher.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the blink counter width calculation.
package pulse_pkg;

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  // Wide enough to hold the larger of the two load values without wrapping.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter holding requests that arrived during a blink.
// Simultaneous inc and dec leave the count unchanged.
module pend_counter
  import pulse_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = (count_q == MAX);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle request pulses into HOLD_CYCLES-high / GAP_CYCLES-low blinks.
// Define PULSE_STRETCH_PENDING_EN to queue requests that arrive mid-blink.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HOLD_CYCLES = 100000,
  parameter int GAP_CYCLES  = 50000,
  parameter int PEND_W      = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pi,
  output logic lo,
  output logic busy,
  output logic dropped
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          dropped_q, dropped_d;
  logic          cnt_zero;
  logic          extra_req;   // request that cannot start a blink right now
  logic          pend_nz;

`ifdef PULSE_STRETCH_PENDING_EN
  logic              pend_dec;
  logic              pend_sat;
  logic [PEND_W-1:0] pend_count;

  // A queued request is consumed whenever the FSM is free to start a blink.
  assign pend_dec = pend_nz && ((state_q == IDLE) || ((state_q == GAP) && cnt_zero));

  pend_counter #(
    .W(PEND_W)
  ) u_pend (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (extra_req),
    .dec     (pend_dec),
    .count   (pend_count),
    .sat     (pend_sat)
  );

  assign pend_nz = |pend_count;
`else
  assign pend_nz = 1'b0;
`endif

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    extra_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        extra_req = pi & pend_nz;
        if (pi || pend_nz) begin
          state_d = ON;
          cnt_d   = HOLD_LD;
        end
      end
      ON: begin
        extra_req = pi;
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          // Queued work has priority; a fresh pi with nothing queued starts directly.
          extra_req = pi & pend_nz;
          if (pend_nz || pi) begin
            state_d = ON;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          extra_req = pi;
          cnt_d     = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    lo_d   = (state_d == ON);
    busy_d = (state_d != IDLE);
`ifdef PULSE_STRETCH_PENDING_EN
    dropped_d = extra_req & pend_sat & ~pend_dec;
`else
    dropped_d = extra_req;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lo_q      <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign lo      = lo_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher (HOLD=4, GAP=2, PEND_W=2); follows
// PULSE_STRETCH_PENDING_EN to pick queued or dropping expectations.
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int PW = 2;
`ifdef PULSE_STRETCH_PENDING_EN
  localparam int PMAX = (1 << PW) - 1;
`else
  localparam int PMAX = 0;
`endif

  logic clk;
  logic reset_n;
  logic pi;
  logic lo;
  logic busy;
  logic dropped;

  int checks;
  int errors;

  // Reference model: a blink is described by the edge it started on.
  bit m_active;
  int m_start;
  int m_pend;
  bit m_drop;
  int edge_n;

  typedef struct {
    logic pi;
    logic lo;
    logic busy;
    logic dropped;
  } vec_t;

  vec_t tv[8];

  pulse_stretcher #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .PEND_W      (PW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pi      (pi),
    .lo      (lo),
    .busy    (busy),
    .dropped (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_start  = 0;
    m_pend   = 0;
    m_drop   = 1'b0;
  endtask

  task automatic model_step(input logic p);
    edge_n++;
    m_drop = 1'b0;
    if (m_active && (edge_n == m_start + H + G)) begin
      if (m_pend > 0) begin
        m_start = edge_n;
        if (!p) m_pend--;
      end else if (p) begin
        m_start = edge_n;
      end else begin
        m_active = 1'b0;
      end
    end else if (m_active) begin
      if (p) begin
        if (m_pend < PMAX) m_pend++;
        else m_drop = 1'b1;
      end
    end else if (p) begin
      m_active = 1'b1;
      m_start  = edge_n;
    end
  endtask

  // One clock: drive pi, sample 1 time unit after the edge, compare to the model.
  task automatic cyc(input logic p);
    logic exp_lo;
    pi = p;
    @(posedge clk);
    #1;
    model_step(p);
    exp_lo = m_active && ((edge_n - m_start) < H);
    chk("model_lo", lo, exp_lo);
    chk("model_busy", busy, m_active);
    chk("model_dropped", dropped, m_drop);
  endtask

  task automatic run_seq(input string nm, input int n, input logic [31:0] pm,
                         input logic [31:0] lm, input logic [31:0] bm,
                         input logic [31:0] dm);
    for (int i = 0; i < n; i++) begin
      cyc(pm[i]);
      chk({nm, "_lo"}, lo, lm[i]);
      chk({nm, "_busy"}, busy, bm[i]);
      chk({nm, "_dropped"}, dropped, dm[i]);
      $display("%s idx=%0d pi=%b lo=%b busy=%b dropped=%b", nm, i, pm[i], lo, busy, dropped);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    edge_n  = 0;
    pi      = 1'b0;
    reset_n = 1'b0;
    model_reset();

    // Single blink: pi on the first edge after reset release.
    tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tv[7] = '{1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_lo", lo, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_dropped", dropped, 1'b0);
      $display("reset cycle %0d lo=%b busy=%b dropped=%b", i, lo, busy, dropped);
    end
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].pi);
      chk("tbl_lo", lo, tv[i].lo);
      chk("tbl_busy", busy, tv[i].busy);
      chk("tbl_dropped", dropped, tv[i].dropped);
      $display("table idx=%0d pi=%b lo=%b busy=%b dropped=%b", i, tv[i].pi, lo, busy, dropped);
    end
    idle(4);

`ifdef PULSE_STRETCH_PENDING_EN
    run_seq("queue3", 20, 32'h0000_000D, 32'h0000_F3CF, 32'h0003_FFFF, 32'h0);
    idle(4);
    run_seq("sat", 26, 32'h0000_001F, 32'h003C_F3CF, 32'h00FF_FFFF, 32'h0000_0010);
    idle(4);
`else
    run_seq("nopend", 14, 32'h0000_0045, 32'h0000_03CF, 32'h0000_0FFF, 32'h0000_0004);
    idle(4);
`endif

    // Reset in the middle of a blink with requests queued behind it.
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_lo", lo, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_dropped", dropped, 1'b0);
    $display("mid-blink reset lo=%b busy=%b dropped=%b", lo, busy, dropped);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(16);

    for (int i = 0; i < 500; i++) begin
      logic p;
      p = ($urandom_range(0, 99) < 25);
      cyc(p);
      if (p) $display("rnd idx=%0d pi=1 lo=%b busy=%b dropped=%b pend_model=%0d", i, lo, busy, dropped, m_pend);
    end
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
